// File: rtl/bias_mux_controller.sv
// TFT panel bias rail sequencer: break-before-make switching between NORMAL, IDLE_LOW and SLEEP rail patterns.
// Optional staggered rail turn-on is compiled in with `define BIAS_MUX_STAGGER_EN.
module bias_mux_controller #(
    parameter int DEAD_TIME      = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bias_mode_select,
    output logic       bias_busy,
    output logic       bias_ready,
    output logic       v_pd_n,
    output logic       v_col_n,
    output logic       v_rg_n
);

    localparam logic [1:0] MODE_NORMAL   = 2'b00;
    localparam logic [1:0] MODE_IDLE_LOW = 2'b01;
    localparam logic [1:0] MODE_SLEEP    = 2'b10;

    localparam int CNT_MAX = (DEAD_TIME > SETTLE_CYCLES) ? DEAD_TIME : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    generate
        if (DEAD_TIME < 1 || SETTLE_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_param_check
            $error("bias_mux_controller: timing parameters must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_STABLE,
        ST_BREAK,
        ST_APPLY,
        ST_SETTLE
    } state_t;

    // Rail vector is {pd, col, rg}, active-low.
    function automatic logic [2:0] pattern(input logic [1:0] mode);
        logic [2:0] p;
        case (mode)
            MODE_NORMAL:   p = 3'b000;
            MODE_IDLE_LOW: p = 3'b001;
            default:       p = 3'b111;
        endcase
        return p;
    endfunction

    logic [1:0]       sync1_reg;
    logic [1:0]       sync2_reg;
    logic [1:0]       target_now;
    logic [1:0]       target_reg;
    logic [1:0]       applied_mode_reg;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       rails_reg;
    logic             busy_reg;
    logic             ready_reg;

`ifdef BIAS_MUX_STAGGER_EN
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam logic [STAG_W-1:0] STAG_RELOAD = STAG_W'(STAGGER_CYCLES - 1);

    logic [2:0]        pending_reg;
    logic [STAG_W-1:0] stag_cnt_reg;
    logic [2:0]        lowest;

    // Lowest pending bit first gives the rg, col, pd turn-on order.
    assign lowest = pending_reg & (~pending_reg + 3'd1);
`endif

    // Reserved encoding behaves exactly like SLEEP, including the equality check.
    assign target_now = (sync2_reg == 2'b11) ? MODE_SLEEP : sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= MODE_SLEEP;
            sync2_reg <= MODE_SLEEP;
        end else begin
            sync1_reg <= bias_mode_select;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_STABLE;
            target_reg       <= MODE_SLEEP;
            applied_mode_reg <= MODE_SLEEP;
            cnt_reg          <= '0;
            rails_reg        <= 3'b111;
            busy_reg         <= 1'b0;
            ready_reg        <= 1'b0;
`ifdef BIAS_MUX_STAGGER_EN
            pending_reg      <= 3'b000;
            stag_cnt_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                ST_STABLE: begin
                    rails_reg <= pattern(applied_mode_reg);
                    if (target_now != applied_mode_reg) begin
                        target_reg <= target_now;
                        state_reg  <= ST_BREAK;
                        cnt_reg    <= '0;
                        rails_reg  <= 3'b111;
                        busy_reg   <= 1'b1;
                        ready_reg  <= 1'b0;
                    end
                end
                ST_BREAK: begin
                    rails_reg <= 3'b111;
                    if (cnt_reg == DEAD_LAST) begin
                        state_reg <= ST_APPLY;
                        cnt_reg   <= '0;
`ifdef BIAS_MUX_STAGGER_EN
                        pending_reg  <= ~pattern(target_reg);
                        stag_cnt_reg <= '0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_APPLY: begin
                    applied_mode_reg <= target_reg;
`ifdef BIAS_MUX_STAGGER_EN
                    if (stag_cnt_reg != '0) begin
                        stag_cnt_reg <= stag_cnt_reg - STAG_W'(1);
                    end else if (pending_reg == 3'b000) begin
                        state_reg <= ST_SETTLE;
                        cnt_reg   <= '0;
                    end else begin
                        rails_reg   <= rails_reg & ~lowest;
                        pending_reg <= pending_reg & ~lowest;
                        if ((pending_reg & ~lowest) == 3'b000) begin
                            state_reg <= ST_SETTLE;
                            cnt_reg   <= '0;
                        end else begin
                            stag_cnt_reg <= STAG_RELOAD;
                        end
                    end
`else
                    rails_reg <= pattern(target_reg);
                    state_reg <= ST_SETTLE;
                    cnt_reg   <= '0;
`endif
                end
                ST_SETTLE: begin
                    // Extra terminal cycle makes enable-to-ready SETTLE_CYCLES + 1.
                    if (cnt_reg == SETTLE_LAST) begin
                        state_reg <= ST_STABLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_STABLE;
                    rails_reg <= 3'b111;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bias_busy  = busy_reg;
    assign bias_ready = ready_reg;
    assign v_pd_n     = rails_reg[2];
    assign v_col_n    = rails_reg[1];
    assign v_rg_n     = rails_reg[0];

endmodule

// File: tb/tb_bias_mux_controller.sv
// Scoreboard bench for bias_mux_controller: stimulus queues expected settled patterns,
// a negedge monitor checks pattern, latency and ordering whenever ready rises.
module tb_bias_mux_controller;

    localparam int DEAD_TIME     = 16;
    localparam int SETTLE_CYCLES = 64;

    logic       clk;
    logic       rst_n;
    logic [1:0] bias_mode_select;
    logic       bias_busy;
    logic       bias_ready;
    logic       v_pd_n;
    logic       v_col_n;
    logic       v_rg_n;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc          = 0;
    int busy_pulses  = 0;
    int rise_cyc     = 0;
    int ones_run     = 0;
    int max_ones_run = 0;
    bit enable_seen  = 0;
    logic       prev_busy  = 0;
    logic       prev_ready = 0;
    logic [2:0] prev_rails = 3'b111;
    logic [2:0] exp_q[$];

    bias_mux_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bias_mode_select (bias_mode_select),
        .bias_busy        (bias_busy),
        .bias_ready       (bias_ready),
        .v_pd_n           (v_pd_n),
        .v_col_n          (v_col_n),
        .v_rg_n           (v_rg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic int rails_now();
        return int'({v_pd_n, v_col_n, v_rg_n});
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [2:0] rails;
        logic [2:0] exp_pat;
        cyc++;
        rails = {v_pd_n, v_col_n, v_rg_n};
        if (!rst_n) begin
            prev_busy  = 1'b0;
            prev_ready = 1'b0;
            prev_rails = 3'b111;
            ones_run   = 0;
        end else begin
            if (bias_busy && !prev_busy) begin
                busy_pulses++;
                rise_cyc    = cyc;
                enable_seen = 0;
                ones_run    = 0;
            end
            if (bias_busy && rails == 3'b111) begin
                ones_run++;
                if (ones_run > max_ones_run) max_ones_run = ones_run;
            end
            if (bias_busy && !enable_seen && ((prev_rails & ~rails) != 3'b000)) begin
                enable_seen = 1;
                check("enable_latency", cyc - rise_cyc, DEAD_TIME + 1);
            end
            if (bias_ready && !prev_ready) begin
                check("ready_latency", cyc - rise_cyc, DEAD_TIME + SETTLE_CYCLES + 2);
                check("ready_while_busy", int'(bias_busy), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    exp_pat = exp_q.pop_front();
                    check("settled_pattern", int'(rails), int'(exp_pat));
                end
            end
            prev_busy  = bias_busy;
            prev_ready = bias_ready;
            prev_rails = rails;
        end
    end

    initial begin
        int b0;
        int c0;
        rst_n            = 1'b0;
        bias_mode_select = 2'b00;

        // Reset state, then NORMAL requested at release
        wait_cycles(3);
        check("reset_rails", rails_now(), 7);
        check("reset_busy", int'(bias_busy), 0);
        check("reset_ready", int'(bias_ready), 0);
        exp_q.push_back(3'b000);
        rst_n = 1'b1;
        wait_cycles(25);
        check("normal_within_25", rails_now(), 0);
        wait_cycles(65);
        check("ready_within_90", int'(bias_ready), 1);
        check("busy_after_90", int'(bias_busy), 0);
        wait_cycles(10);
        check("boot_busy_pulses", busy_pulses, 1);

        // NORMAL -> IDLE_LOW
        max_ones_run = 0;
        b0 = busy_pulses;
        bias_mode_select = 2'b01;
        c0 = cyc;
        exp_q.push_back(3'b001);
        wait_cycles(5);
        check("busy_latency", rise_cyc - c0, 3);
        check("busy_in_break", int'(bias_busy), 1);
        wait_cycles(200);
        check("idle_low_rails", rails_now(), 1);
        check("idle_low_ready", int'(bias_ready), 1);
        check("idle_low_pulses", busy_pulses - b0, 1);
        check("dead_time_all_off", int'(max_ones_run >= DEAD_TIME), 1);

        // IDLE_LOW -> SLEEP
        b0 = busy_pulses;
        bias_mode_select = 2'b10;
        exp_q.push_back(3'b111);
        wait_cycles(200);
        check("sleep_rails", rails_now(), 7);
        check("sleep_ready", int'(bias_ready), 1);
        check("sleep_pulses", busy_pulses - b0, 1);

        // Reserved code while in SLEEP: no sequence
        b0 = busy_pulses;
        bias_mode_select = 2'b11;
        wait_cycles(50);
        check("reserved_pulses", busy_pulses - b0, 0);
        check("reserved_rails", rails_now(), 7);
        check("reserved_busy", int'(bias_busy), 0);

        // Changes during a sequence: first completes, one more ends in SLEEP
        b0 = busy_pulses;
        bias_mode_select = 2'b00;
        exp_q.push_back(3'b000);
        wait_cycles(10);
        bias_mode_select = 2'b01;
        wait_cycles(2);
        bias_mode_select = 2'b10;
        exp_q.push_back(3'b111);
        wait_cycles(400);
        check("retarget_pulses", busy_pulses - b0, 2);
        check("retarget_rails", rails_now(), 7);
        check("retarget_ready", int'(bias_ready), 1);

        // Reset asserted mid-SETTLE
        b0 = busy_pulses;
        bias_mode_select = 2'b00;
        exp_q.push_back(3'b000);
        wait_cycles(50);
        check("mid_settle_busy", int'(bias_busy), 1);
        check("mid_settle_rails", rails_now(), 0);
        rst_n = 1'b0;
        #2;
        check("async_reset_rails", rails_now(), 7);
        check("async_reset_busy", int'(bias_busy), 0);
        check("async_reset_ready", int'(bias_ready), 0);
        exp_q.delete();
        bias_mode_select = 2'b10;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(20);
        check("post_reset_busy", int'(bias_busy), 0);
        check("post_reset_ready", int'(bias_ready), 0);
        check("post_reset_rails", rails_now(), 7);
        check("post_reset_pulses", busy_pulses - b0, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_mux_controller.md
# bias_mux_controller

Selects and sequences the TFT panel bias rail pattern (photodiode, column, row-gate) from a 2-bit mode request. It sits between the panel power/mode control logic and the active-low bias switch enables on the analog front end. Every mode change goes through a break-before-make sequence: all rails off, dead time, new pattern, settle. Busy/ready status is reported to the requester.

## Interface
- DEAD_TIME, 16: cycles all rails are held off before a new pattern is applied (≥1).
- SETTLE_CYCLES, 64: cycles after the pattern is applied before ready asserts (≥1).
- STAGGER_CYCLES, 8: per-rail spacing when staggered turn-on is compiled in (≥1).
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bias_mode_select  in  2  requested mode: 00 NORMAL, 01 IDLE_LOW, 10 SLEEP, 11 reserved (treated as SLEEP); asynchronous to clk.
- bias_busy  out  1  high while a transition sequence is in progress.
- bias_ready  out  1  high when the applied pattern matches the latched request and has settled.
- v_pd_n  out  1  photodiode bias enable, active-low.
- v_col_n  out  1  column bias enable, active-low.
- v_rg_n  out  1  row-gate bias enable, active-low.

## Operation
- Patterns (v_pd_n, v_col_n, v_rg_n): NORMAL 0,0,0; IDLE_LOW 0,0,1; SLEEP and reserved 1,1,1.
- bias_mode_select passes through a 2-flop synchronizer. 11 maps to SLEEP before comparison.
- Register `applied_mode` holds the pattern currently driven. It resets to SLEEP.
- States:
  - STABLE: outputs = pattern(applied_mode). If synced target ≠ applied_mode, latch target and go to BREAK.
  - BREAK: all outputs 1, count DEAD_TIME cycles, then go to APPLY.
  - APPLY: set applied_mode = latched target and drive its pattern, then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to STABLE.
- Target SLEEP: BREAK already yields the final pattern, but APPLY and SETTLE still run so timing is uniform.
- Request changes during BREAK/APPLY/SETTLE are ignored until STABLE. The sequence in flight completes, then STABLE re-compares and starts a new sequence if needed. No sequence is ever aborted.
- bias_busy = 1 in BREAK/APPLY/SETTLE, 0 in STABLE.
- bias_ready = 1 only in STABLE after at least one completed sequence. It is 0 whenever busy is 1.
- Outputs are registered and glitch-free. No output goes 1→0 (enable) except in APPLY or a stagger step.

## Timing
- Reset (asynchronous): v_pd_n = v_col_n = v_rg_n = 1, bias_busy = 0, bias_ready = 0, state STABLE, applied_mode SLEEP, counters 0.
- Reset asserted mid-sequence forces the reset values immediately (all rails off).
- Request-change to busy: 3 cycles (2 sync + 1 detect).
- Busy to first enable: DEAD_TIME + 1 cycles.
- Enable to ready: SETTLE_CYCLES + 1 cycles.
- With defaults, a NORMAL request present at reset release shows all rails 0 within 25 cycles and ready within 90 cycles.
- Equal-mode request (for example SLEEP while in SLEEP, or 11 while in SLEEP): no sequence, and busy stays 0.

## Configuration
- BIAS_MUX_STAGGER_EN defined: APPLY enables rails in a fixed order, one new rail every STAGGER_CYCLES:
  - order is v_rg_n, then v_col_n, then v_pd_n;
  - rails the target leaves off are skipped;
  - SETTLE starts after the last enable.
- BIAS_MUX_STAGGER_EN undefined: all enabled rails change in the same cycle. STAGGER_CYCLES is unused.

## Test plan
- Reset with mode 00, release, wait 100 cycles -> v_pd_n = v_col_n = v_rg_n = 0, bias_ready = 1, bias_busy = 0.
- From NORMAL, set mode 01, wait 1000 cycles -> outputs 0,0,1 and ready = 1. During the sequence: busy = 1 and ≥DEAD_TIME cycles with all outputs 1.
- From IDLE_LOW, set mode 10, wait 1000 cycles -> outputs 1,1,1, ready = 1, with exactly one busy pulse.
- Set mode 11 while in SLEEP -> no busy pulse, outputs stay 1,1,1.
- Change mode 00→01→10 within 5 cycles during a sequence -> the first sequence completes, then exactly one more ends in SLEEP.
- Assert rst_n low mid-SETTLE -> all outputs 1, busy = 0, ready = 0 before the next clock edge.
